unary_stream_sequencer: RTL

Sequencer and two-way arbiter for a single shared bit-serial unary arithmetic unit. Accepts binary operand words from two requesters, grants the unit round-robin, clears it, streams the granted word LSB-first into the unit's `a`/`ready` inputs, and collects `valid`-qualified `y` bits into a binary result word. Returns the result with requester ID, bit count and timeout flag over a valid/ready response channel. Sits between the binary host fabric and one unary unit instance.

---
 rtl/unary_stream_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/unary_stream_sequencer.sv
// unary_stream_sequencer
//   Sequencer and round-robin arbiter in front of one shared bit-serial unary
//   unit. A granted operand word goes through three steps. The sequencer
//   clears the unit, then streams the word LSB-first on unit_a/unit_ready.
//   It collects the valid-qualified unit_y bits into a result word. The result
//   is returned on a valid/ready response channel.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_valid[1:0]        per-requester job request
//   req_data0/1           operand words
//   req_ready[1:0]        one-hot acceptance (combinational, IDLE only)
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/id/count     collected word, issuing requester, collected bit count
//   rsp_timeout           fewer than INPUT_WIDTH bits were collected
//   unit_clear/a/ready    drive to the unary unit
//   unit_valid/y          result stream from the unary unit
module unary_stream_sequencer #(
    parameter int INPUT_WIDTH  = 16,
    parameter int COUNT_WIDTH  = $clog2(INPUT_WIDTH + 1),
    parameter int DRAIN_CYCLES = INPUT_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [INPUT_WIDTH-1:0] req_data0,
    input  logic [INPUT_WIDTH-1:0] req_data1,
    output logic [1:0]             req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [INPUT_WIDTH-1:0] rsp_data,
    output logic                   rsp_id,
    output logic [COUNT_WIDTH-1:0] rsp_count,
    output logic                   rsp_timeout,
    output logic                   unit_clear,
    output logic                   unit_a,
    output logic                   unit_ready,
    input  logic                   unit_valid,
    input  logic                   unit_y
);

    localparam int DRAIN_WIDTH = $clog2(DRAIN_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] FULL       = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_IDX   = COUNT_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [DRAIN_WIDTH-1:0] DRAIN_LAST = DRAIN_WIDTH'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_q, last_d;      // requester granted last
    logic                   id_q, id_d;
    logic [INPUT_WIDTH-1:0] op_q, op_d;          // shifted right once per streamed bit
    logic [COUNT_WIDTH-1:0] bit_idx_q, bit_idx_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DRAIN_WIDTH-1:0] drain_ctr_q, drain_ctr_d;
    logic [INPUT_WIDTH-1:0] result_q, result_d;
    logic                   grant_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= '0;
            bit_idx_q   <= '0;
            count_q     <= '0;
            drain_ctr_q <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            op_q        <= op_d;
            bit_idx_q   <= bit_idx_d;
            count_q     <= count_d;
            drain_ctr_q <= drain_ctr_d;
            result_q    <= result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        op_d        = op_q;
        bit_idx_d   = bit_idx_q;
        count_d     = count_q;
        drain_ctr_d = drain_ctr_q;
        result_d    = result_q;
        req_ready   = 2'b00;
        grant_id    = 1'b0;

        // Collection runs ahead of the state decisions so that STREAM/DRAIN
        // exits can see the post-edge count.
        if ((state_q == S_STREAM || state_q == S_DRAIN) && unit_valid && count_q != FULL) begin
            result_d = result_q | ({{(INPUT_WIDTH-1){1'b0}}, unit_y} << count_q);
            count_d  = count_q + COUNT_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    // On a tie, the requester not granted last wins.
                    grant_id    = (req_valid == 2'b11) ? ~last_q : req_valid[1];
                    req_ready   = grant_id ? 2'b10 : 2'b01;
                    id_d        = grant_id;
                    op_d        = grant_id ? req_data1 : req_data0;
                    bit_idx_d   = '0;
                    count_d     = '0;
                    drain_ctr_d = '0;
                    result_d    = '0;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_STREAM;
            S_STREAM: begin
                op_d      = op_q >> 1;
                bit_idx_d = bit_idx_q + COUNT_WIDTH'(1);
                if (bit_idx_q == LAST_IDX)
                    state_d = (count_d == FULL) ? S_RESP : S_DRAIN;
            end
            S_DRAIN: begin
                drain_ctr_d = drain_ctr_q + DRAIN_WIDTH'(1);
                if (count_d == FULL || drain_ctr_q == DRAIN_LAST)
                    state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    last_d  = id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Unit-side strobes decode straight from state so reset drops them at once.
    assign unit_clear  = (state_q == S_CLEAR);
    assign unit_ready  = (state_q == S_STREAM);
    assign unit_a      = (state_q == S_STREAM) & op_q[0];

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = result_q;
    assign rsp_id      = id_q;
    assign rsp_count   = count_q;
    assign rsp_timeout = (state_q == S_RESP) && (count_q != FULL);

endmodule
